// File: rtl/logic_fold_unit.sv
// logic_fold_unit: registered bitwise AND/OR/XOR/NAND over operand pairs or folded bursts, valid/ready on both sides
module logic_fold_unit #(
  parameter int W = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    op,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Q,
  output logic [CW-1:0] count
);
  typedef enum logic [1:0] {IDLE, FOLD, HOLD} state_t;
  state_t state_q, state_d;
  logic [W-1:0] q_q, q_d, acc_q, acc_d, first, nxt;
  logic [CW-1:0] count_q, count_d, beats_q, beats_d, nbeats;
  logic [1:0] op_q, op_d;
  logic accept;
  function automatic logic [W-1:0] apply(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    return o == 2'd0 ? x & y : o == 2'd1 ? x | y : o == 2'd2 ? x ^ y : ~(x & y);
  endfunction
  assign in_ready  = !rst && (state_q != HOLD || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == HOLD;
  assign Q         = q_q;
  assign count     = count_q;
  assign first     = apply(op, A, B);
  assign nxt       = apply(op_q, acc_q, A);
  assign nbeats    = beats_q + 1'b1;
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    count_d = count_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    op_d    = op_q;
    if (accept && state_q != FOLD) begin
      if (mode) begin
        acc_d   = first;
        beats_d = CW'(1);
        op_d    = op;
      end
      if (!mode || last) begin
        q_d     = first;
        count_d = CW'(1);
        state_d = HOLD;
      end else state_d = FOLD;
    end else if (accept) begin
      acc_d   = nxt;
      beats_d = nbeats;
      // a burst that reaches MAX_BEATS closes even without last
      if (last || nbeats == CW'(MAX_BEATS)) begin
        q_d     = nxt;
        count_d = nbeats;
        state_d = HOLD;
      end
    end else if (state_q == HOLD && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      count_q <= '0;
      acc_q   <= '0;
      beats_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      op_q    <= op_d;
    end
  end
endmodule
